id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline register with integrated load-use hazard detection.
- Captures decoded operands and control from decode each cycle. Presents registered rs1/rs2/rd and control to the EX-stage forwarding unit and ALU.
- On a load-use dependency, inserts one bubble into EX and holds the IF/ID stages.
- Also handles branch flush, downstream hold and a stall-cycle counter.

Parameters:
- XLEN, 32, datapath and PC width
- REG_ADDR_W, 5, register index width
- ALU_OP_W, 4, ALU opcode width
- CNT_W, 16, stall counter width (saturating)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  decode slot holds a real instruction
- id_pc  in  XLEN  PC of decode instruction
- id_rs1, id_rs2, id_rd  in  REG_ADDR_W  register indices
- id_uses_rs2  in  1  instruction reads rs2 (R-type/store/branch)
- id_rs1_data, id_rs2_data  in  XLEN  register file read data
- id_imm  in  XLEN  sign-extended immediate
- id_alu_op  in  ALU_OP_W  ALU operation
- id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg  in  1  control bits
- flush  in  1  branch/jump taken in EX; kill decode instruction
- ex_hold  in  1  downstream (MEM busy) freeze of EX
- wb_reg_write  in  1  WB write enable
- wb_rd  in  REG_ADDR_W  WB destination index
- wb_data  in  XLEN  WB write data
- ex_valid  out  1  EX slot valid
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN  registered copies
- ex_rs1, ex_rs2, ex_rd  out  REG_ADDR_W  registered indices (to forwarding unit)
- ex_alu_op  out  ALU_OP_W  registered
- ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg  out  1  registered
- load_use_stall  out  1  combinational; hold PC and IF/ID this cycle
- stall_cnt  out  CNT_W  count of cycles with load_use_stall=1

Behaviour:
- Reset (rst_n=0 at posedge):
  - All outputs registered to 0, including stall_cnt and indices.
  - load_use_stall is forced to 0 while rst_n=0.
- Hazard detection, combinational from current registers and ID inputs:
  - haz = ex_valid & ex_mem_read & (ex_rd!=0) & id_valid & (ex_rd==id_rs1 | (id_uses_rs2 & ex_rd==id_rs2)).
  - load_use_stall = haz & !flush & !ex_hold.
- Register update priority at each posedge:
  1. rst_n=0 -> reset.
  2. flush -> bubble. ex_valid=0, all control bits 0, indices 0; data fields don't-care, implementation loads 0.
  3. ex_hold -> all registers keep their value. flush outranks ex_hold.
  4. load_use_stall -> bubble, same as flush encoding.
  5. Otherwise capture all ID inputs; ex_valid=id_valid.
- When id_valid=0, control bits are captured as 0 regardless of inputs, so a bubble never writes.
- Latency: one cycle ID->EX. A load-use pair costs exactly one bubble: the next cycle haz=0 because ex_mem_read=0.
- ex_rd==0 never triggers a stall, even if the load targets x0.
- stall_cnt:
  - Increments by 1 on each posedge where load_use_stall=1.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Unaffected by flush/ex_hold except through load_use_stall.

Optional Feature:
- Macro: ID_EX_WB_BYPASS_EN.
- Defined: on capture, if wb_reg_write & wb_rd!=0 & wb_rd==id_rs1, latch wb_data into ex_rs1_data instead of id_rs1_data. Same rule for rs2. Covers register-file write/read in the same cycle.
- Undefined: wb_* inputs are ignored (left unconnected internally); the register file must be write-first.

Decomposition:
- Shared package pipe_pkg: XLEN, REG_ADDR_W, ALU_OP_W, ALU opcode localparams, and a control-bundle typedef ctrl_t {alu_op, alu_src, mem_read, mem_write, reg_write, mem_to_reg}. The bubble constant CTRL_NOP is also in pipe_pkg.
- One natural sub-module: load_use_detect (pure combinational haz equation), reused by a future dual-issue decoder.
- Pipeline register and stall counter stay in id_ex_stage.

Test Plan:
- Reset: rst_n=0 for 2 cycles with id_valid=1, id_reg_write=1 -> ex_valid=0, ex_reg_write=0, stall_cnt=0, load_use_stall=0.
- Load-use on rs1:
  - Stimulus: cycle N captures lw x5 (mem_read=1, rd=5); cycle N+1 decode add x6,x5,x7.
  - Response: load_use_stall=1 in N+1; N+2 ex_valid=0; N+2 with same ID inputs -> load_use_stall=0, add captured in N+3; stall_cnt=1.
- rs2 gating: lw x5 in EX, ID sw with rs2=5 and id_uses_rs2=1 -> stall. Same with id_uses_rs2=0 (addi using imm) -> no stall. Load to x0 -> no stall.
- Priority:
  - flush=1 together with haz=1 -> load_use_stall=0 and bubble captured.
  - ex_hold=1 for 3 cycles -> ex_* unchanged, stall_cnt unchanged.
  - flush=1 & ex_hold=1 -> bubble.
- Counter saturation: CNT_W=4, 20 consecutive stall cycles -> stall_cnt stops at 15.
- Bypass with ID_EX_WB_BYPASS_EN:
  - Stimulus: wb_reg_write=1, wb_rd=3, wb_data=0xDEADBEEF, id_rs1=3, id_rs1_data=0x0.
  - Response: ex_rs1_data=0xDEADBEEF. Without the macro: 0x0. wb_rd=0 -> no bypass.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline types for the decode/execute boundary: widths, ALU opcodes
// and the control bundle carried alongside each instruction.
package pipe_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ALU_OP_W   = 4;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'd8;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'd9;

  typedef struct packed {
    logic [ALU_OP_W-1:0] alu_op;
    logic                alu_src;
    logic                mem_read;
    logic                mem_write;
    logic                reg_write;
    logic                mem_to_reg;
  } ctrl_t;

  // Bubble encoding: no memory access and no register write.
  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard equation: the instruction in EX is a load whose destination
// is read by the instruction in decode. Purely combinational.
module load_use_detect #(
  parameter int REG_ADDR_W = pipe_pkg::REG_ADDR_W
) (
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs2,
  output logic                  haz
);

  logic rd_nonzero;
  logic rs1_match;
  logic rs2_match;

  // x0 is hardwired, so a load targeting it never produces a usable value.
  assign rd_nonzero = (ex_rd != '0);
  assign rs1_match  = (ex_rd == id_rs1);
  assign rs2_match  = id_uses_rs2 && (ex_rd == id_rs2);

  assign haz = ex_valid && ex_mem_read && rd_nonzero && id_valid &&
               (rs1_match || rs2_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush,
// downstream hold and a saturating stall counter.
// Optional build macro ID_EX_WB_BYPASS_EN: forwards the WB write into captured operands.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int XLEN       = pipe_pkg::XLEN,
  parameter int REG_ADDR_W = pipe_pkg::REG_ADDR_W,
  parameter int ALU_OP_W   = pipe_pkg::ALU_OP_W,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [XLEN-1:0]       id_pc,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_uses_rs2,
  input  logic [XLEN-1:0]       id_rs1_data,
  input  logic [XLEN-1:0]       id_rs2_data,
  input  logic [XLEN-1:0]       id_imm,
  input  logic [ALU_OP_W-1:0]   id_alu_op,
  input  logic                  id_alu_src,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_reg_write,
  input  logic                  id_mem_to_reg,
  input  logic                  flush,
  input  logic                  ex_hold,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  output logic                  ex_valid,
  output logic [XLEN-1:0]       ex_pc,
  output logic [XLEN-1:0]       ex_rs1_data,
  output logic [XLEN-1:0]       ex_rs2_data,
  output logic [XLEN-1:0]       ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rs1,
  output logic [REG_ADDR_W-1:0] ex_rs2,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [ALU_OP_W-1:0]   ex_alu_op,
  output logic                  ex_alu_src,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_reg_write,
  output logic                  ex_mem_to_reg,
  output logic                  load_use_stall,
  output logic [CNT_W-1:0]      stall_cnt
);

  ctrl_t           ex_ctrl;
  ctrl_t           id_ctrl;
  logic            haz;
  logic            bubble;
  logic [XLEN-1:0] rs1_capture;
  logic [XLEN-1:0] rs2_capture;

  load_use_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_load_use_detect (
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_ctrl.mem_read),
    .ex_rd       (ex_rd),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs2 (id_uses_rs2),
    .haz         (haz)
  );

  // A flush or hold already keeps the consumer out of EX, so no extra bubble.
  assign load_use_stall = rst_n && haz && !flush && !ex_hold;
  assign bubble         = flush || load_use_stall;

  // Invalid decode slots carry NOP control so a bubble can never write.
  always_comb begin
    id_ctrl = CTRL_NOP;
    if (id_valid) begin
      id_ctrl.alu_op     = id_alu_op;
      id_ctrl.alu_src    = id_alu_src;
      id_ctrl.mem_read   = id_mem_read;
      id_ctrl.mem_write  = id_mem_write;
      id_ctrl.reg_write  = id_reg_write;
      id_ctrl.mem_to_reg = id_mem_to_reg;
    end
  end

`ifdef ID_EX_WB_BYPASS_EN
  // Same-cycle register-file write: take the value being written back.
  assign rs1_capture = (wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs1)) ? wb_data
                                                                             : id_rs1_data;
  assign rs2_capture = (wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs2)) ? wb_data
                                                                             : id_rs2_data;
`else
  logic unused_wb;
  assign unused_wb   = ^{wb_reg_write, wb_rd, wb_data};
  assign rs1_capture = id_rs1_data;
  assign rs2_capture = id_rs2_data;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_ctrl     <= CTRL_NOP;
    end else if (bubble) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_ctrl     <= CTRL_NOP;
    end else if (!ex_hold) begin
      ex_valid    <= id_valid;
      ex_pc       <= id_pc;
      ex_rs1_data <= rs1_capture;
      ex_rs2_data <= rs2_capture;
      ex_imm      <= id_imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_ctrl     <= id_ctrl;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (load_use_stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign ex_alu_op     = ex_ctrl.alu_op;
  assign ex_alu_src    = ex_ctrl.alu_src;
  assign ex_mem_read   = ex_ctrl.mem_read;
  assign ex_mem_write  = ex_ctrl.mem_write;
  assign ex_reg_write  = ex_ctrl.reg_write;
  assign ex_mem_to_reg = ex_ctrl.mem_to_reg;

endmodule
